// File: rtl/sdcard_multibuf.sv
// Multi-buffer sector cache between the CPU MMIO bus and the SPI-mode SD byte engine.
// Each of NBUF 512-byte buffers has a tag, a valid bit and a dirty bit. Read, write and
// flush commands run through one transfer FSM with an inactivity timeout.
//
// state | meaning
// IDLE  | no transfer; CMD accepted when ctl_ready is high
// ISSUE | rd/wr strobe held with ctl_addr stable until ctl_ready falls
// XFER  | 512 bytes moved, one per byte_avail / next rising edge
// DRAIN | wait for ctl_ready high, update tag/flags, chain next op or finish
module sdcard_multibuf #(
    parameter int NBUF        = 4,
    parameter bit AUTO_WB     = 1'b1,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq,
    input  logic        sd_ncd,
    output logic [31:0] ctl_addr,
    output logic        ctl_rd,
    output logic        ctl_wr,
    input  logic [7:0]  ctl_dout,
    input  logic        ctl_byte_avail,
    output logic [7:0]  ctl_din,
    input  logic        ctl_next,
    input  logic        ctl_ready
);
    localparam int BW = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int MW = BW + 7;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DRAIN} state_t;

    state_t            state;
    logic [2:0]        sel, cur_buf, first_idx, next_idx;
    logic [31:0]       req_addr, rd_addr;
    logic [31:0]       tag [NBUF];
    logic [NBUF-1:0]   valid, dirty, wbmask;
    logic              err, op_wr, pend_rd, flush_mode;
    logic [1:0]        irq_stat, irq_en;
    logic [8:0]        cnt;
    logic [23:0]       shreg;
    logic              avail_q, next_q;
    logic [TW-1:0]     tcnt;
    logic [31:0]       mem [NBUF*128];

    logic              busy, hbuf_ok, sel_ok, host_mem_we, xfer_mem_we, progress, cmd_wr;
    logic              avail_rise, next_rise, first_found, next_found;
    logic [2:0]        hbuf;
    logic [MW-1:0]     hidx, xidx;
    logic [31:0]       xword;
    logic [7:0]        xbyte;

    // The driver writes REQ_ADDR byte-reversed; the register holds the real address.
    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    assign busy        = (state != IDLE);
    assign hbuf        = a[11:9];
    assign hbuf_ok     = int'(hbuf) < NBUF;
    assign sel_ok      = int'(sel) < NBUF;
    assign hidx        = {hbuf[BW-1:0], a[8:2]};
    assign xidx        = {cur_buf[BW-1:0], cnt[8:2]};
    assign xword       = mem[xidx];
    assign avail_rise  = ctl_byte_avail & ~avail_q;
    assign next_rise   = ctl_next & ~next_q;
    assign wbmask      = valid & dirty;
    assign irq         = |(irq_stat & irq_en);
    assign cmd_wr      = we && (a == 16'h1008) && (state == IDLE) && ctl_ready;
    // The buffer being transferred is locked against host writes while busy.
    assign host_mem_we = we && (a[15:12] == 4'h0) && hbuf_ok && !(busy && hbuf == cur_buf);
    assign xfer_mem_we = (state == XFER) && !op_wr && avail_rise && (cnt[1:0] == 2'd3);
    assign progress    = ((state == ISSUE) && !ctl_ready) ||
                         ((state == XFER) && (op_wr ? next_rise : avail_rise)) ||
                         ((state == DRAIN) && ctl_ready);

    // Byte of the current buffer word to present on a write; byte 0 is bits [31:24].
    always_comb begin
        case (cnt[1:0])
            2'd0:    xbyte = xword[31:24];
            2'd1:    xbyte = xword[23:16];
            2'd2:    xbyte = xword[15:8];
            default: xbyte = xword[7:0];
        endcase
    end

    // Flush scan: lowest dirty buffer overall, and lowest dirty buffer above cur_buf.
    always_comb begin
        first_found = 1'b0;
        first_idx   = 3'd0;
        next_found  = 1'b0;
        next_idx    = 3'd0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            if (wbmask[i]) begin
                first_found = 1'b1;
                first_idx   = 3'(i);
                if (i > int'(cur_buf)) begin
                    next_found = 1'b1;
                    next_idx   = 3'(i);
                end
            end
        end
    end

    // Combinational MMIO read mux.
    always_comb begin
        spo = '0;
        if (a[15:12] == 4'h0) begin
            if (hbuf_ok) spo = mem[hidx];
        end else begin
            case (a)
                16'h1000: spo = {29'b0, sel};
                16'h1004: spo = bswap(req_addr);
                16'h100C: if (sel_ok) spo = tag[sel[BW-1:0]];
                16'h2000: spo = {7'b0, sd_ncd, 24'b0};
                16'h2010: spo = {busy, err, 14'b0, 8'(valid), 8'(dirty)};
                16'h2014: spo = {30'b0, irq_stat};
                16'h2018: spo = {30'b0, irq_en};
                default:  spo = '0;
            endcase
        end
    end

    // Sector RAM: host port and transfer port; transfer write is last so it wins a collision.
    always_ff @(posedge clk) begin
        if (host_mem_we) mem[hidx] <= d;
        if (xfer_mem_we) mem[xidx] <= {shreg, ctl_dout};
    end

    // Registers, flags and the transfer FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel        <= '0;
            req_addr   <= '0;
            rd_addr    <= '0;
            for (int i = 0; i < NBUF; i++) tag[i] <= '0;
            valid      <= '0;
            dirty      <= '0;
            err        <= 1'b0;
            irq_stat   <= '0;
            irq_en     <= '0;
            op_wr      <= 1'b0;
            pend_rd    <= 1'b0;
            flush_mode <= 1'b0;
            cur_buf    <= '0;
            cnt        <= '0;
            shreg      <= '0;
            avail_q    <= 1'b0;
            next_q     <= 1'b0;
            tcnt       <= T_LOAD;
            ctl_addr   <= '0;
            ctl_rd     <= 1'b0;
            ctl_wr     <= 1'b0;
            ctl_din    <= '0;
        end else begin
            avail_q <= ctl_byte_avail;
            next_q  <= ctl_next;
            if (we) begin
                case (a)
                    16'h1000: sel      <= d[2:0];
                    16'h1004: req_addr <= bswap(d) & 32'hFFFF_FE00;
                    16'h2014: irq_stat <= irq_stat & ~d[1:0];
                    16'h2018: irq_en   <= d[1:0];
                    default: ;
                endcase
            end
            if (host_mem_we && valid[hbuf[BW-1:0]]) dirty[hbuf[BW-1:0]] <= 1'b1;

            case (state)
                IDLE: begin
                    tcnt <= T_LOAD;
                    if (cmd_wr) begin
                        case (d[1:0])
                            2'd1: if (sel_ok) begin
                                err        <= 1'b0;
                                cur_buf    <= sel;
                                rd_addr    <= req_addr;
                                flush_mode <= 1'b0;
                                state      <= ISSUE;
                                if (AUTO_WB && valid[sel[BW-1:0]] && dirty[sel[BW-1:0]]) begin
                                    op_wr    <= 1'b1;
                                    pend_rd  <= 1'b1;
                                    ctl_addr <= tag[sel[BW-1:0]];
                                    ctl_wr   <= 1'b1;
                                end else begin
                                    op_wr    <= 1'b0;
                                    pend_rd  <= 1'b0;
                                    ctl_addr <= req_addr;
                                    ctl_rd   <= 1'b1;
                                end
                            end
                            2'd2: if (sel_ok) begin
                                err        <= 1'b0;
                                cur_buf    <= sel;
                                op_wr      <= 1'b1;
                                pend_rd    <= 1'b0;
                                flush_mode <= 1'b0;
                                ctl_addr   <= req_addr;
                                ctl_wr     <= 1'b1;
                                state      <= ISSUE;
                            end
                            2'd3: begin
                                err     <= 1'b0;
                                pend_rd <= 1'b0;
                                if (first_found) begin
                                    flush_mode <= 1'b1;
                                    op_wr      <= 1'b1;
                                    cur_buf    <= first_idx;
                                    ctl_addr   <= tag[first_idx[BW-1:0]];
                                    ctl_wr     <= 1'b1;
                                    state      <= ISSUE;
                                end else begin
                                    irq_stat[0] <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (!progress) begin
                        if (tcnt == '0) begin
                            ctl_rd                  <= 1'b0;
                            ctl_wr                  <= 1'b0;
                            err                     <= 1'b1;
                            irq_stat[1]             <= 1'b1;
                            valid[cur_buf[BW-1:0]]  <= 1'b0;
                            pend_rd                 <= 1'b0;
                            flush_mode              <= 1'b0;
                            state                   <= IDLE;
                        end else begin
                            tcnt <= tcnt - 1'b1;
                        end
                    end else begin
                        tcnt <= T_LOAD;
                        case (state)
                            ISSUE: begin
                                ctl_rd <= 1'b0;
                                ctl_wr <= 1'b0;
                                cnt    <= '0;
                                state  <= XFER;
                            end
                            XFER: begin
                                cnt <= cnt + 1'b1;
                                if (op_wr) ctl_din <= xbyte;
                                else       shreg   <= {shreg[15:0], ctl_dout};
                                if (cnt == 9'd511) state <= DRAIN;
                            end
                            DRAIN: begin
                                tag[cur_buf[BW-1:0]]   <= ctl_addr;
                                dirty[cur_buf[BW-1:0]] <= 1'b0;
                                if (!op_wr) valid[cur_buf[BW-1:0]] <= 1'b1;
                                if (pend_rd) begin
                                    pend_rd  <= 1'b0;
                                    op_wr    <= 1'b0;
                                    ctl_addr <= rd_addr;
                                    ctl_rd   <= 1'b1;
                                    state    <= ISSUE;
                                end else if (flush_mode && next_found) begin
                                    cur_buf  <= next_idx;
                                    ctl_addr <= tag[next_idx[BW-1:0]];
                                    ctl_wr   <= 1'b1;
                                    state    <= ISSUE;
                                end else begin
                                    flush_mode  <= 1'b0;
                                    irq_stat[0] <= 1'b1;
                                    state       <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdcard_multibuf.sv
// Bench for sdcard_multibuf: register vectors from a table, then host command sequences
// against a byte-level controller model with an expected-operation scoreboard.
module tb_sdcard_multibuf;
    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a = '0;
    logic [31:0] d = '0;
    logic        we = 1'b0;
    logic [31:0] spo;
    logic        irq;
    logic        sd_ncd = 1'b1;
    logic [31:0] ctl_addr;
    logic        ctl_rd, ctl_wr;
    logic [7:0]  ctl_dout = '0;
    logic        ctl_byte_avail = 1'b0;
    logic [7:0]  ctl_din;
    logic        ctl_next = 1'b0;
    logic        ctl_ready = 1'b1;

    always #5 clk = ~clk;

    sdcard_multibuf #(.NBUF(4), .AUTO_WB(1'b1), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
        .sd_ncd(sd_ncd), .ctl_addr(ctl_addr), .ctl_rd(ctl_rd), .ctl_wr(ctl_wr),
        .ctl_dout(ctl_dout), .ctl_byte_avail(ctl_byte_avail), .ctl_din(ctl_din),
        .ctl_next(ctl_next), .ctl_ready(ctl_ready)
    );

    typedef struct {
        logic [15:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    typedef struct {
        bit          wr;
        logic [31:0] addr;
    } op_t;

    vec_t        vecs[$];
    op_t         exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  wr_bytes [512];

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired, got no event expected event", name);
    endtask

    task automatic mmio_wr(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        a = addr; d = data; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic mmio_rd(input logic [15:0] addr, output logic [31:0] data);
        @(negedge clk);
        a = addr;
        #1 data = spo;
    endtask

    task automatic expect_op(input bit wr, input logic [31:0] addr);
        op_t o;
        o.wr = wr; o.addr = addr;
        exp_q.push_back(o);
    endtask

    task automatic wait_idle(input int max);
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            mmio_rd(16'h2010, v);
            n++;
        end while (v[31] && n < max);
        if (v[31]) fail_now("idle_wait");
    endtask

    // Controller model: answer one strobe, move bytes, stop early at stall_at (>=0).
    task automatic serve(input int stall_at, input logic [7:0] base);
        int n;
        bit is_wr;
        op_t e;
        n = 0;
        while (!(ctl_rd || ctl_wr) && n < 200) begin @(negedge clk); n++; end
        if (!(ctl_rd || ctl_wr)) begin fail_now("strobe_wait"); return; end
        is_wr = ctl_wr;
        if (exp_q.size() == 0) begin
            fail_now("unexpected_op");
        end else begin
            e = exp_q.pop_front();
            chk("op_kind", 32'(is_wr), 32'(e.wr));
            chk("op_addr", ctl_addr, e.addr);
        end
        repeat (2) @(negedge clk);
        ctl_ready = 1'b0;
        n = 0;
        while ((ctl_rd || ctl_wr) && n < 20) begin @(negedge clk); n++; end
        chk("strobe_drop", 32'(ctl_rd | ctl_wr), 32'd0);
        for (int i = 0; i < 512; i++) begin
            if (i == stall_at) return;
            if (!is_wr) begin
                ctl_dout = base + 8'(i);
                ctl_byte_avail = 1'b1;
                @(negedge clk);
                ctl_byte_avail = 1'b0;
                @(negedge clk);
            end else begin
                ctl_next = 1'b1;
                @(negedge clk);
                ctl_next = 1'b0;
                @(negedge clk);
                @(negedge clk);
                wr_bytes[i] = ctl_din;
            end
        end
        @(negedge clk);
        ctl_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        bit seen;

        // addr, write?, wdata, expected read
        vecs.push_back('{16'h2010, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h2014, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h2018, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h1000, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h1004, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h100C, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h1000, 1'b1, 32'hFFFF_FFFD, 32'h5});
        vecs.push_back('{16'h100C, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h1004, 1'b1, 32'h1234_5678, 32'h0034_5678});
        vecs.push_back('{16'h2018, 1'b1, 32'hFFFF_FFFF, 32'h3});
        vecs.push_back('{16'h2000, 1'b0, 32'h0, 32'h0100_0000});
        vecs.push_back('{16'h3000, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{16'h0A00, 1'b1, 32'h1111_1111, 32'h0});
        vecs.push_back('{16'h040C, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D});
        vecs.push_back('{16'h1000, 1'b1, 32'h0, 32'h0});

        repeat (3) @(negedge clk);
        chk("reset_ctl_rd", 32'(ctl_rd), 32'd0);
        chk("reset_ctl_addr", ctl_addr, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) mmio_wr(vecs[i].addr, vecs[i].wdata);
            mmio_rd(vecs[i].addr, v);
            chk($sformatf("vec%0d_a%04h", i, vecs[i].addr), v, vecs[i].exp);
        end
        chk("irq_idle", 32'(irq), 32'd0);

        // Read sector 0x400 into buffer 0.
        mmio_wr(16'h1004, bswap(32'h400));
        expect_op(1'b0, 32'h400);
        mmio_wr(16'h1008, 32'd1);
        serve(-1, 8'h00);
        wait_idle(50);
        mmio_rd(16'h0000, v); chk("rd_word0", v, 32'h0001_0203);
        mmio_rd(16'h01FC, v); chk("rd_word127", v, 32'hFCFD_FEFF);
        mmio_rd(16'h100C, v); chk("rd_tag", v, 32'h400);
        mmio_rd(16'h2010, v); chk("rd_status", v, 32'h0000_0100);
        mmio_rd(16'h2014, v); chk("rd_irqstat", v, 32'h1);
        chk("rd_irq", 32'(irq), 32'd1);
        mmio_wr(16'h2014, 32'h1);
        #1 chk("irq_w1c", 32'(irq), 32'd0);

        // Write buffer 1 to sector 0x200.
        mmio_wr(16'h0200, 32'hDEAD_BEEF);
        mmio_wr(16'h1000, 32'd1);
        mmio_wr(16'h1004, bswap(32'h200));
        expect_op(1'b1, 32'h200);
        mmio_wr(16'h1008, 32'd2);
        serve(-1, 8'h00);
        wait_idle(50);
        chk("wr_b0", 32'(wr_bytes[0]), 32'hDE);
        chk("wr_b1", 32'(wr_bytes[1]), 32'hAD);
        chk("wr_b2", 32'(wr_bytes[2]), 32'hBE);
        chk("wr_b3", 32'(wr_bytes[3]), 32'hEF);
        mmio_rd(16'h100C, v); chk("wr_tag", v, 32'h200);
        mmio_rd(16'h2010, v); chk("wr_status", v, 32'h0000_0100);
        mmio_wr(16'h2014, 32'h3);

        // Dirty buffer 0 read to a new sector: write-back first, then read.
        mmio_wr(16'h0004, 32'h55AA_55AA);
        mmio_rd(16'h2010, v); chk("awb_dirty", v, 32'h0000_0101);
        mmio_wr(16'h1000, 32'd0);
        mmio_wr(16'h1004, bswap(32'h800));
        expect_op(1'b1, 32'h400);
        expect_op(1'b0, 32'h800);
        mmio_wr(16'h1008, 32'd1);
        serve(-1, 8'h00);
        chk("awb_b0", 32'(wr_bytes[0]), 32'h00);
        chk("awb_b3", 32'(wr_bytes[3]), 32'h03);
        chk("awb_b4", 32'(wr_bytes[4]), 32'h55);
        serve(-1, 8'h80);
        wait_idle(50);
        mmio_rd(16'h0000, v); chk("awb_word0", v, 32'h8081_8283);
        mmio_rd(16'h100C, v); chk("awb_tag", v, 32'h800);
        mmio_rd(16'h2010, v); chk("awb_status", v, 32'h0000_0100);
        mmio_rd(16'h2014, v); chk("awb_irqstat", v, 32'h1);
        mmio_wr(16'h2014, 32'h3);

        // Load buffer 2, dirty buffers 0 and 2, flush.
        mmio_wr(16'h1000, 32'd2);
        mmio_wr(16'h1004, bswap(32'hA00));
        expect_op(1'b0, 32'hA00);
        mmio_wr(16'h1008, 32'd1);
        serve(-1, 8'h10);
        wait_idle(50);
        mmio_wr(16'h2014, 32'h3);
        mmio_wr(16'h0000, 32'h1122_3344);
        mmio_wr(16'h0400, 32'h9988_7766);
        mmio_rd(16'h2010, v); chk("fl_pre_status", v, 32'h0000_0505);
        expect_op(1'b1, 32'h800);
        expect_op(1'b1, 32'hA00);
        mmio_wr(16'h1008, 32'd3);
        serve(-1, 8'h00);
        chk("fl_buf0_b0", 32'(wr_bytes[0]), 32'h11);
        serve(-1, 8'h00);
        chk("fl_buf2_b0", 32'(wr_bytes[0]), 32'h99);
        wait_idle(50);
        mmio_rd(16'h2010, v); chk("fl_status", v, 32'h0000_0500);
        mmio_rd(16'h2014, v); chk("fl_irqstat", v, 32'h1);
        mmio_wr(16'h2014, 32'h3);
        mmio_wr(16'h1008, 32'd3);
        mmio_rd(16'h2014, v); chk("fl_none_irq", v, 32'h1);
        mmio_rd(16'h2010, v); chk("fl_none_status", v, 32'h0000_0500);
        mmio_wr(16'h2014, 32'h3);

        // Stall after 100 bytes of a read into buffer 0.
        mmio_wr(16'h1000, 32'd0);
        mmio_wr(16'h1004, bswap(32'hC00));
        expect_op(1'b0, 32'hC00);
        mmio_wr(16'h1008, 32'd1);
        serve(100, 8'h00);
        mmio_rd(16'h2010, v); chk("to_busy", 32'(v[31]), 32'd1);
        mmio_wr(16'h1008, 32'd2);
        wait_idle(TO + 100);
        mmio_rd(16'h2010, v); chk("to_status", v, 32'h4000_0400);
        mmio_rd(16'h2014, v); chk("to_irqstat", v, 32'h2);
        chk("to_strobes", 32'({ctl_rd, ctl_wr}), 32'd0);
        ctl_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= (ctl_rd | ctl_wr); end
        chk("to_cmd_ignored", 32'(seen), 32'd0);
        mmio_wr(16'h1008, 32'd3);
        mmio_rd(16'h2010, v); chk("to_err_clr", v, 32'h0000_0400);
        mmio_rd(16'h2014, v); chk("to_irqstat2", v, 32'h3);

        // Reset in the middle of a read transfer.
        mmio_wr(16'h1000, 32'd2);
        mmio_wr(16'h1004, bswap(32'hE00));
        expect_op(1'b0, 32'hE00);
        mmio_wr(16'h1008, 32'd1);
        serve(50, 8'h00);
        @(negedge clk);
        a = 16'h2010;
        #1;
        chk("rst_pre_busy", 32'(spo[31]), 32'd1);
        chk("rst_pre_irq", 32'(irq), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(spo[31]), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_strobes", 32'({ctl_rd, ctl_wr}), 32'd0);
        repeat (2) @(negedge clk);
        ctl_ready = 1'b1;
        rst = 1'b1;
        mmio_rd(16'h2010, v); chk("rst_status", v, 32'h0);
        mmio_rd(16'h100C, v); chk("rst_tag", v, 32'h0);
        mmio_rd(16'h2018, v); chk("rst_irqen", v, 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
